// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI command-protocol master. It frames a 2-bit command and an
// 8-bit payload on SS_n/MOSI at the system clock rate. For read-data commands it
// captures the byte the slave returns on MISO.
// Optional build macro SPIM_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module spi_master_ctrl #(
   parameter int unsigned RD_WAIT    = 1,   // turnaround cycles before first MISO sample (0..7)
   parameter int unsigned GAP_CYCLES = 2    // minimum SS_n high cycles between frames (1..15)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic [7:0] tx_data,
   output logic       ready,
   output logic       busy,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
`ifdef SPIM_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int unsigned CNT_W     = 4;
   localparam int unsigned FRAME_W   = 11;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned SEND_LAST = FRAME_W - 1;
   // RECV spans 7 cycles: the entry edge takes the first sample, the exit edge the last
   localparam int unsigned RECV_LAST = BYTE_W - 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_SEND,
      ST_WAIT,
      ST_RECV,
      ST_GAP
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic [1:0]           cmd_q, cmd_d;
   logic [BYTE_W-1:0]    shift_q, shift_d;
   logic [BYTE_W-1:0]    rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 ss_n_q, ss_n_d;
   logic                 mosi_q, mosi_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 sample_en;
`ifdef SPIM_FRAME_CNT_EN
   logic [15:0]          frame_cnt_q, frame_cnt_d;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: phase lengths are timed by cnt_q, which restarts on every state change
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LEAD;
         ST_LEAD: state_d = ST_SEND;
         ST_SEND: begin
            if (cnt_q == CNT_W'(SEND_LAST)) begin
               if (cmd_q == 2'b11) begin
                  state_d = (RD_WAIT == 0) ? ST_RECV : ST_WAIT;
               end else begin
                  state_d = ST_GAP;
               end
            end
         end
         ST_WAIT: if (cnt_q == CNT_W'(RD_WAIT - 1)) state_d = ST_RECV;
         ST_RECV: if (cnt_q == CNT_W'(RECV_LAST)) state_d = ST_GAP;
         ST_GAP:  if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output/datapath next values: outputs follow the state being entered, so they stay registered
   always_comb begin
      ss_n_d     = 1'b1;
      mosi_d     = 1'b0;
      ready_d    = 1'b0;
      busy_d     = 1'b1;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      frame_d    = frame_q;
      cmd_d      = cmd_q;
      shift_d    = shift_q;
      cnt_d      = '0;
      sample_en  = (state_d == ST_RECV) || (state_q == ST_RECV);
`ifdef SPIM_FRAME_CNT_EN
      frame_cnt_d = frame_cnt_q;
`endif

      if ((state_d == state_q) && (state_q != ST_IDLE)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_d)
         ST_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
         ST_LEAD, ST_WAIT, ST_RECV: ss_n_d = 1'b0;
         ST_SEND: begin
            ss_n_d  = 1'b0;
            mosi_d  = frame_q[FRAME_W-1];
            frame_d = {frame_q[FRAME_W-2:0], 1'b0};
         end
         default: ;
      endcase

      // Latch the request on acceptance; the first bit repeats cmd[1] as the slave's R/W select
      if ((state_q == ST_IDLE) && start) begin
         frame_d = {cmd[1], cmd, tx_data};
         cmd_d   = cmd;
      end

      if (sample_en) begin
         shift_d = {shift_q[BYTE_W-2:0], MISO};
      end

      if ((state_q == ST_RECV) && (state_d == ST_GAP)) begin
         rx_data_d  = {shift_q[BYTE_W-2:0], MISO};
         rx_valid_d = 1'b1;
      end

`ifdef SPIM_FRAME_CNT_EN
      if ((state_d == ST_GAP) && (state_q != ST_GAP)) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
`endif
   end

   // Output and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         frame_q    <= '0;
         cmd_q      <= '0;
         shift_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         frame_q    <= frame_d;
         cmd_q      <= cmd_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         ss_n_q     <= ss_n_d;
         mosi_q     <= mosi_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
      end
   end

`ifdef SPIM_FRAME_CNT_EN
   // Completed-frame counter, bumped on entry to GAP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign ready    = ready_q;
   assign busy     = busy_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign SS_n     = ss_n_q;
   assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl with default parameters.
module tb_spi_master_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] cmd;
   logic [7:0] tx_data;
   logic       ready;
   logic       busy;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
`ifdef SPIM_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int n_pass = 0;
   int n_chk  = 0;
   int n_fail = 0;
   logic [7:0] last_rx;
   logic [7:0] ram [256];

   spi_master_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .cmd      (cmd),
      .tx_data  (tx_data),
      .ready    (ready),
      .busy     (busy),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO)
`ifdef SPIM_FRAME_CNT_EN
      ,
      .frame_cnt(frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One frame; abort_k>0 asserts rst after edge abort_k, poke5 pulses start mid-frame
   task automatic frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] mb,
                        input int abort_k, input bit poke5);
      logic [10:0] seq;
      bit          rd;
      int          ss_low, rv_cnt, rv_edge, rdy_edge;
      logic [7:0]  rv_data;
      seq      = {c[1], c, d};
      rd       = (c == 2'b11);
      ss_low   = 0;
      rv_cnt   = 0;
      rv_edge  = -1;
      rdy_edge = -1;
      rv_data  = 8'h00;
      start    = 1'b1;
      cmd      = c;
      tx_data  = d;
      @(posedge clk); #1;
      start   = 1'b0;
      cmd     = ~c;
      tx_data = ~d;
      chk("lead_ss_n",  32'(SS_n),  32'd0);
      chk("lead_ready", 32'(ready), 32'd0);
      chk("lead_busy",  32'(busy),  32'd1);
      chk("lead_mosi",  32'(MOSI),  32'd0);
      if (!SS_n) ss_low++;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (abort_k == k) begin
            rst = 1'b1;
            #1;
            chk("abort_ss_n",     32'(SS_n),     32'd1);
            chk("abort_mosi",     32'(MOSI),     32'd0);
            chk("abort_ready",    32'(ready),    32'd1);
            chk("abort_busy",     32'(busy),     32'd0);
            chk("abort_rx_valid", 32'(rx_valid), 32'd0);
            chk("abort_rx_data",  32'(rx_data),  32'd0);
            last_rx = 8'h00;
            rst     = 1'b0;
            MISO    = 1'b0;
            return;
         end
         if (k <= 11) chk($sformatf("mosi_bit%0d", k), 32'(MOSI), 32'(seq[11-k]));
         if (poke5 && k == 5) begin
            start   = 1'b1;
            cmd     = 2'b00;
            tx_data = 8'hFF;
         end
         if (poke5 && k == 6) start = 1'b0;
         if (rd && k >= 12 && k <= 19) MISO = mb[19-k];
         else MISO = 1'b0;
         if (!SS_n) ss_low++;
         if (rx_valid) begin
            rv_cnt++;
            rv_edge = k;
            rv_data = rx_data;
         end
         if (ready) begin
            rdy_edge = k;
            break;
         end
      end
      chk("ss_low_cycles", 32'(ss_low),   rd ? 32'd20 : 32'd12);
      chk("ready_edge",    32'(rdy_edge), rd ? 32'd22 : 32'd14);
      chk("rx_valid_cnt",  32'(rv_cnt),   rd ? 32'd1  : 32'd0);
      if (rd) begin
         chk("rx_valid_edge", 32'(rv_edge), 32'd20);
         chk("rx_data_pulse", 32'(rv_data), 32'(mb));
         last_rx = mb;
      end
      chk("rx_data_hold", 32'(rx_data), 32'(last_rx));
   endtask

   initial begin
      logic [7:0] addrs [4];
      logic [7:0] a;
      logic [7:0] v;
      addrs   = '{8'h00, 8'h7F, 8'h80, 8'hFF};
      rst     = 1'b1;
      start   = 1'b0;
      cmd     = 2'b00;
      tx_data = 8'h00;
      MISO    = 1'b0;
      last_rx = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ss_n",     32'(SS_n),     32'd1);
      chk("rst_mosi",     32'(MOSI),     32'd0);
      chk("rst_ready",    32'(ready),    32'd1);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_rx_data",  32'(rx_data),  32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Write-addr 0x5A, then read-data returning 0xC3
      frame(2'b00, 8'h5A, 8'h00, 0, 1'b0);
      frame(2'b11, 8'h00, 8'hC3, 0, 1'b0);

      // start pulsed mid-frame is ignored and not queued
      frame(2'b01, 8'hA5, 8'h00, 0, 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
         chk("no_queue_ss_n",  32'(SS_n),  32'd1);
         chk("no_queue_ready", 32'(ready), 32'd1);
      end

      // Reset mid-SEND, then a clean frame
      frame(2'b00, 8'h3C, 8'h00, 6, 1'b0);
      @(posedge clk); #1;
      frame(2'b01, 8'h81, 8'h00, 0, 1'b0);

      // Small write/read sweep against a RAM-style slave model
      foreach (addrs[i]) begin
         a = addrs[i];
         v = a ^ 8'h96;
         frame(2'b00, a, 8'h00, 0, 1'b0);
         frame(2'b01, v, 8'h00, 0, 1'b0);
         ram[a] = v;
      end
      foreach (addrs[i]) begin
         a = addrs[i];
         frame(2'b10, a, 8'h00, 0, 1'b0);
         frame(2'b11, 8'h00, ram[a], 0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
